// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-channel FSM states.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: byte-enabled write port, registered read port.
// Read and write share clk; a same-address collision returns the old word.
module dp_bram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Byte-lane write; the array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; output holds its value whenever re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave in front of a word-addressed RAM. Independent read and
// write channels; out-of-range accesses answer DECERR and never touch memory.
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  endfunction

  wr_state_e   wr_state, wr_state_nxt;
  logic        wr_go, aw_lat, w_lat;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_hit, mem_we;
  logic [1:0]  bresp_q;

  logic        ar_hs_p0, ar_hit_p0;
  logic        rvld_p1, rhit_p1;
  logic [1:0]  rresp_p1;
  logic [31:0] bram_q;

  logic        unused_ok;
  assign unused_ok = ^{axi_awprot, axi_arprot, axi_araddr[1:0], wr_addr[1:0]};

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) wr_state <= IDLE;
    else       wr_state <= wr_state_nxt;
  end

  // Write FSM next state, channel readies, and the write strobe.
  always_comb begin
    wr_state_nxt = wr_state;
    axi_awready  = 1'b0;
    axi_wready   = 1'b0;
    axi_bvalid   = 1'b0;
    wr_go        = 1'b0;
    aw_lat       = 1'b0;
    w_lat        = 1'b0;
    case (wr_state)
      IDLE: begin
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        if (axi_awvalid && axi_wvalid) begin
          wr_go        = 1'b1;
          wr_state_nxt = RESP;
        end else if (axi_awvalid) begin
          aw_lat       = 1'b1;
          wr_state_nxt = HAVE_AW;
        end else if (axi_wvalid) begin
          w_lat        = 1'b1;
          wr_state_nxt = HAVE_W;
        end
      end
      HAVE_AW: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          wr_go        = 1'b1;
          wr_state_nxt = RESP;
        end
      end
      HAVE_W: begin
        axi_awready = 1'b1;
        if (axi_awvalid) begin
          wr_go        = 1'b1;
          wr_state_nxt = RESP;
        end
      end
      RESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) wr_state_nxt = IDLE;
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  // Latch whichever half of a write arrives first; data path has no reset.
  always_ff @(posedge clk) begin
    if (aw_lat) aw_addr_q <= axi_awaddr;
    if (w_lat) begin
      w_data_q <= axi_wdata;
      w_strb_q <= axi_wstrb;
    end
  end

  assign wr_addr = (wr_state == HAVE_AW) ? aw_addr_q : axi_awaddr;
  assign wr_data = (wr_state == HAVE_W)  ? w_data_q  : axi_wdata;
  assign wr_strb = (wr_state == HAVE_W)  ? w_strb_q  : axi_wstrb;
  assign wr_hit  = addr_hit(wr_addr);
  assign mem_we  = wr_go && wr_hit && !reset;

  // Write response code, captured when the write is performed.
  always_ff @(posedge clk) begin
    if (reset)      bresp_q <= AXI_RESP_OKAY;
    else if (wr_go) bresp_q <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
  end

  assign axi_bresp = bresp_q;

  // ---- read stage p0: address handshake and decode ----
  assign axi_arready = !rvld_p1 || axi_rready;
  assign ar_hs_p0    = axi_arvalid && axi_arready;
  assign ar_hit_p0   = addr_hit(axi_araddr);

  // ---- read stage p1: response valid and code, held under backpressure ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_p1  <= 1'b0;
      rhit_p1  <= 1'b0;
      rresp_p1 <= AXI_RESP_OKAY;
    end else if (ar_hs_p0) begin
      rvld_p1  <= 1'b1;
      rhit_p1  <= ar_hit_p0;
      rresp_p1 <= ar_hit_p0 ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    end else if (axi_rready) begin
      rvld_p1  <= 1'b0;
    end
  end

  assign axi_rvalid = rvld_p1;
  assign axi_rresp  = rresp_p1;
  assign axi_rdata  = rhit_p1 ? bram_q : 32'h0;

  dp_bram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .be    (wr_strb),
    .waddr (wr_addr[ADDR_WIDTH+1:2]),
    .wdata (wr_data),
    .re    (ar_hs_p0),
    .raddr (axi_araddr[ADDR_WIDTH+1:2]),
    .rdata (bram_q)
  );

endmodule

// File: doc/axi_lite_ram.md
# axi_lite_ram

AXI4-Lite slave backed by an on-chip word-addressed RAM; it is the responder on the far end of the pipeline's imem and dmem master ports. It accepts single-beat reads and writes, applies byte strobes, and returns OKAY or DECERR responses. One instance serves instruction fetch (read-only use) and another serves data; both are identical.

## Interface
- ADDR_WIDTH, 12: word-address bits; capacity 2^ADDR_WIDTH 32-bit words (default 16 KiB).
- BASE_ADDR, 32'h00000000: byte base address; must be aligned to the capacity.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- axi_awaddr  in  32  write address.
- axi_awprot  in  3  ignored.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i].
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_bresp  out  2  write response.
- axi_bvalid  out  1  write response valid.
- axi_bready  in  1  write response ready.
- axi_araddr  in  32  read address.
- axi_arprot  in  3  ignored.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.

## Operation
- Address decode: in range iff addr[31:2+ADDR_WIDTH] == BASE_ADDR[31:2+ADDR_WIDTH]. Word index is addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored; misaligned accesses hit the containing word.
- Write FSM states are IDLE, HAVE_AW, HAVE_W and RESP.
  - IDLE: awready=1, wready=1. AW only -> HAVE_AW (latch address). W only -> HAVE_W (latch data and strobes). Both in the same cycle -> perform the write, go to RESP.
  - HAVE_AW: awready=0, wready=1. On the W handshake, perform the write and go to RESP.
  - HAVE_W: awready=1, wready=0. On the AW handshake, perform the write and go to RESP.
  - RESP: awready=0, wready=0, bvalid=1. On bready, go to IDLE.
- Performing a write when the address is in range: update the strobed bytes and set bresp=OKAY (2'b00). When out of range: memory is unchanged and bresp=DECERR (2'b11). wstrb=0 is legal: nothing is written and the response is OKAY.
- Read channel: arready = !rvalid || rready, which allows back-to-back reads.
  - On the AR handshake: rvalid=1 next cycle, with rdata set to the word and rresp=OKAY.
  - Out of range: rdata=0, rresp=DECERR.
  - rdata and rresp hold stable while rvalid && !rready.
- The read and write channels are fully independent. When a read and a write to the same word are performed in the same cycle, the read returns the old data (read-first).
- Memory contents are not affected by reset.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0. Write FSM is in IDLE.
- Write: last of AW/W handshaken in cycle N -> bvalid in N+1. The written data is visible to a read handshaken in N+1 or later.
- Write throughput with bready held high is one write every 2 cycles.
- Read: AR in cycle N -> rvalid in N+1. Sustained rate is 1 read per cycle with rready high.
- Backpressure:
  - rready low: rvalid holds and arready=0 until the beat is accepted.
  - bready low: bvalid holds and no new AW/W is accepted.
- Reset asserted mid-transaction: latched AW/W and pending B/R responses are discarded, and outputs return to their reset values on the next edge. A write already performed is not rolled back.

## Structure
- Shared package axi_lite_pkg holds:
  - response constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11;
  - the write FSM state enum.
- Sub-module dp_bram (parameter ADDR_WIDTH): one write port with 4 byte enables and one read port with a registered 1-cycle read, both on clk. It must infer block RAM and has no reset on the array.
- The top level contains the decode, the write FSM, the latch registers, and the read-valid/response registers.

## Test plan
- Reset, then write 32'hDEADBEEF with wstrb=4'hF to BASE_ADDR+0x10 (AW and W together) -> bvalid the next cycle with bresp=00. A read of 0x10 then returns rdata=32'hDEADBEEF, rresp=00, one cycle after AR.
- Write with W two cycles before AW (data 32'h11223344, wstrb=4'b0101) over the word 32'hDEADBEEF -> awready=1 and wready=0 while waiting. The readback is 32'hDE22BE44.
- Write to and read from BASE_ADDR + 4*2^ADDR_WIDTH -> bresp=11 and no memory change. Read returns rresp=11, rdata=0.
- Eight back-to-back reads with rready=1 -> one rvalid per cycle with correct data. Then hold rready=0 for 3 cycles -> rdata stable and arready=0.
- Hold bready=0 after a write, then present a new AW and W -> both are stalled and bvalid stays 1. Release bready -> the next write proceeds.
- Assert reset while in HAVE_AW -> the next cycle shows the reset values. A following W alone does not write memory.
